// File: rtl/disp_7seg_rx.sv
// Multiplexed 7-segment display receiver: debounces {E,Q}, decodes digits and publishes whole frames.
// Latency: a digit is accepted on its SETTLE_CYCLES-th identical sample and the frame is published one CLK later.
// No backpressure: CE-paced sampling; optional DP capture is enabled by macro DISP_7SEG_RX_DP_EN.
module disp_7seg_rx #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [7:0]  FRAME_MASK    = 8'hFF
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        CE,
  input  logic [7:0]  E,
  input  logic [7:0]  Q,
  output logic [31:0] DIGITS,
  output logic [7:0]  DP_OUT,
  output logic [7:0]  INVALID,
  output logic        FRAME_STB,
  output logic        ERR
);

  localparam logic [7:0] SETTLE_MAX = 8'(SETTLE_CYCLES);
  localparam logic [7:0] SETTLE_HIT = 8'(SETTLE_CYCLES - 1);
`ifdef DISP_7SEG_RX_DP_EN
  localparam logic [15:0] CMP_MASK = 16'hFFFF;
`else
  localparam logic [15:0] CMP_MASK = 16'hFF7F;
`endif

  logic [15:0] prev_smp;
  logic [7:0]  stable_cnt;
  logic [7:0]  cnt_nxt;
  logic        accepted;
  logic        acc_q;
  logic [7:0]  seen;
  logic [7:0]  seen_nxt;
  logic [31:0] nib_sh;
  logic [7:0]  inv_sh;
  logic [7:0]  e_n;
  logic        same;
  logic        multi;
  logic        one_hot;
  logic        accept;
  logic        frame_go;
  logic [2:0]  pos;
  logic [3:0]  dec_nib;
  logic        dec_inv;

  assign e_n     = ~E;
  assign same    = ((({E, Q} ^ prev_smp) & CMP_MASK) == 16'h0000);
  assign multi   = (e_n & (e_n - 8'd1)) != 8'h00;
  assign one_hot = (e_n != 8'h00) && !multi;

  // A multi-enable sample restarts the dwell even if it repeats.
  always_comb begin
    cnt_nxt = 8'd0;
    if (same && !multi) begin
      cnt_nxt = (stable_cnt >= SETTLE_MAX) ? SETTLE_MAX : stable_cnt + 8'd1;
    end
  end

  assign accept   = CE && one_hot && (cnt_nxt == SETTLE_HIT) && !accepted;
  assign frame_go = acc_q && ((seen & FRAME_MASK) == FRAME_MASK);

  always_comb begin
    pos = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (e_n[i]) pos = 3'(i);
    end
  end

  always_comb begin
    seen_nxt = frame_go ? 8'h00 : seen;
    if (accept) seen_nxt = seen_nxt | e_n;
  end

  always_comb begin
    dec_nib = 4'h0;
    dec_inv = 1'b0;
    case (Q[6:0])
      7'h40: dec_nib = 4'h0;
      7'h79: dec_nib = 4'h1;
      7'h24: dec_nib = 4'h2;
      7'h30: dec_nib = 4'h3;
      7'h19: dec_nib = 4'h4;
      7'h12: dec_nib = 4'h5;
      7'h02: dec_nib = 4'h6;
      7'h78: dec_nib = 4'h7;
      7'h00: dec_nib = 4'h8;
      7'h10: dec_nib = 4'h9;
      7'h08: dec_nib = 4'hA;
      7'h03: dec_nib = 4'hB;
      7'h46: dec_nib = 4'hC;
      7'h21: dec_nib = 4'hD;
      7'h06: dec_nib = 4'hE;
      7'h0E: dec_nib = 4'hF;
      default: dec_inv = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      prev_smp   <= 16'hFFFF;
      stable_cnt <= 8'd0;
      accepted   <= 1'b0;
      acc_q      <= 1'b0;
      seen       <= 8'h00;
      nib_sh     <= 32'h0;
      inv_sh     <= 8'h00;
      DIGITS     <= 32'h0;
      INVALID    <= 8'h00;
      FRAME_STB  <= 1'b0;
      ERR        <= 1'b0;
    end else begin
      acc_q     <= accept;
      ERR       <= CE && multi;
      FRAME_STB <= frame_go;
      seen      <= seen_nxt;
      if (CE) begin
        stable_cnt <= cnt_nxt;
        if (!same || multi) begin
          prev_smp <= {E, Q};
          accepted <= 1'b0;
        end else if (accept) begin
          accepted <= 1'b1;
        end
      end
      if (accept) begin
        nib_sh[4*pos +: 4] <= dec_nib;
        inv_sh[pos]        <= dec_inv;
      end
      if (frame_go) begin
        DIGITS  <= nib_sh;
        INVALID <= inv_sh;
      end
    end
  end

`ifdef DISP_7SEG_RX_DP_EN
  logic [7:0] dp_sh;

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      dp_sh  <= 8'h00;
      DP_OUT <= 8'h00;
    end else begin
      if (accept) dp_sh[pos] <= ~Q[7];
      if (frame_go) DP_OUT <= dp_sh;
    end
  end
`else
  assign DP_OUT = 8'h00;
`endif

endmodule

// File: tb/tb_disp_7seg_rx.sv
// Directed bench for disp_7seg_rx: one instance framing positions 0-1, one framing position 0 only.
module tb_disp_7seg_rx;

  logic       CLK = 1'b0;
  logic       CLR;
  logic       CE;
  logic [7:0] E;
  logic [7:0] Q;

  logic [31:0] digits_a, digits_b;
  logic [7:0]  dp_a, dp_b, inv_a, inv_b;
  logic        stb_a_o, stb_b_o, err_a_o, err_b_o;

  int checks = 0;
  int errors = 0;
  int stb_a = 0;
  int stb_b = 0;
  int err_a = 0;

`ifdef DISP_7SEG_RX_DP_EN
  localparam logic [7:0] DP_EXP = 8'h01;
`else
  localparam logic [7:0] DP_EXP = 8'h00;
`endif

  disp_7seg_rx #(.SETTLE_CYCLES(4), .FRAME_MASK(8'h03)) u_dut (
    .CLK(CLK), .CLR(CLR), .CE(CE), .E(E), .Q(Q),
    .DIGITS(digits_a), .DP_OUT(dp_a), .INVALID(inv_a),
    .FRAME_STB(stb_a_o), .ERR(err_a_o)
  );

  disp_7seg_rx #(.SETTLE_CYCLES(4), .FRAME_MASK(8'h01)) u_dut1 (
    .CLK(CLK), .CLR(CLR), .CE(CE), .E(E), .Q(Q),
    .DIGITS(digits_b), .DP_OUT(dp_b), .INVALID(inv_b),
    .FRAME_STB(stb_b_o), .ERR(err_b_o)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (stb_a_o) stb_a++;
    if (stb_b_o) stb_b++;
    if (err_a_o) err_a++;
  end

  task automatic drive(input logic [7:0] e, input logic [7:0] q, input int n);
    for (int i = 0; i < n; i++) begin
      E = e; Q = q; CE = 1'b1;
      @(posedge CLK); #1;
    end
  endtask

  task automatic idle(input int n);
    CE = 1'b0; E = 8'hFF; Q = 8'hFF;
    repeat (n) begin
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_reset;
    CLR = 1'b1; CE = 1'b0; E = 8'hFF; Q = 8'hFF;
    #2 CLR = 1'b0;
    #2;
    checks++; if (digits_a !== 32'h0) begin errors++; $display("FAIL reset_digits actual=%h required=%h", digits_a, 32'h0); end
    checks++; if (inv_a !== 8'h00) begin errors++; $display("FAIL reset_invalid actual=%h required=%h", inv_a, 8'h00); end
    checks++; if (dp_a !== 8'h00) begin errors++; $display("FAIL reset_dp actual=%h required=%h", dp_a, 8'h00); end
    checks++; if ({stb_a_o, err_a_o} !== 2'b00) begin errors++; $display("FAIL reset_pulses actual=%b required=%b", {stb_a_o, err_a_o}, 2'b00); end
    @(posedge CLK); #1 CLR = 1'b1;
    idle(2);
    checks++; if (stb_a !== 0) begin errors++; $display("FAIL reset_no_stb actual=%0d required=%0d", stb_a, 0); end
  endtask

  task automatic test_capture;
    int s;
    s = stb_a;
    drive(8'hFE, 8'hC0, 4);
    idle(2);
    checks++; if (stb_a - s !== 0) begin errors++; $display("FAIL capture_partial actual=%0d required=%0d", stb_a - s, 0); end
    drive(8'hFD, 8'hF9, 4);
    idle(2);
    checks++; if (stb_a - s !== 1) begin errors++; $display("FAIL capture_stb actual=%0d required=%0d", stb_a - s, 1); end
    checks++; if (digits_a !== 32'h00000010) begin errors++; $display("FAIL capture_digits actual=%h required=%h", digits_a, 32'h10); end
    checks++; if (inv_a !== 8'h00) begin errors++; $display("FAIL capture_invalid actual=%h required=%h", inv_a, 8'h00); end
    checks++; if (dp_a !== 8'h00) begin errors++; $display("FAIL capture_dp actual=%h required=%h", dp_a, 8'h00); end
  endtask

  task automatic test_glitch;
    int sa, sb;
    sa = stb_a; sb = stb_b;
    drive(8'hFE, 8'hA4, 3);
    drive(8'hFE, 8'hB0, 1);
    drive(8'hFE, 8'hB0, 4);
    idle(2);
    checks++; if (stb_b - sb !== 1) begin errors++; $display("FAIL glitch_single_stb actual=%0d required=%0d", stb_b - sb, 1); end
    checks++; if (digits_b[3:0] !== 4'h3) begin errors++; $display("FAIL glitch_nibble actual=%h required=%h", digits_b[3:0], 4'h3); end
    drive(8'hFD, 8'hF9, 4);
    idle(2);
    checks++; if (stb_a - sa !== 1) begin errors++; $display("FAIL glitch_frame_stb actual=%0d required=%0d", stb_a - sa, 1); end
    checks++; if (digits_a[7:0] !== 8'h13) begin errors++; $display("FAIL glitch_digits actual=%h required=%h", digits_a[7:0], 8'h13); end
  endtask

  task automatic test_multi_enable;
    int sa, sb, se;
    sa = stb_a; sb = stb_b; se = err_a;
    drive(8'hFC, 8'hC0, 1);
    checks++; if (err_a_o !== 1'b1) begin errors++; $display("FAIL multi_err_high actual=%b required=%b", err_a_o, 1'b1); end
    idle(1);
    checks++; if (err_a_o !== 1'b0) begin errors++; $display("FAIL multi_err_low actual=%b required=%b", err_a_o, 1'b0); end
    checks++; if (err_a - se !== 1) begin errors++; $display("FAIL multi_err_count actual=%0d required=%0d", err_a - se, 1); end
    drive(8'hFD, 8'hF9, 4);
    idle(2);
    checks++; if (stb_a - sa !== 0) begin errors++; $display("FAIL multi_seen_kept actual=%0d required=%0d", stb_a - sa, 0); end
    checks++; if (stb_b - sb !== 0) begin errors++; $display("FAIL multi_no_accept actual=%0d required=%0d", stb_b - sb, 0); end
    drive(8'hFE, 8'hC0, 4);
    idle(2);
    checks++; if (stb_a - sa !== 1) begin errors++; $display("FAIL multi_then_frame actual=%0d required=%0d", stb_a - sa, 1); end
    se = err_a;
    drive(8'hFF, 8'hFF, 5);
    idle(1);
    checks++; if (err_a - se !== 0) begin errors++; $display("FAIL blank_enable_err actual=%0d required=%0d", err_a - se, 0); end
  endtask

  task automatic test_dp_invalid;
    int sa;
    sa = stb_a;
    drive(8'hFE, 8'h40, 4);
    drive(8'hFD, 8'hF9, 4);
    idle(2);
    checks++; if (dp_a !== DP_EXP) begin errors++; $display("FAIL dp_capture actual=%h required=%h", dp_a, DP_EXP); end
    checks++; if (digits_a[7:0] !== 8'h10) begin errors++; $display("FAIL dp_digits actual=%h required=%h", digits_a[7:0], 8'h10); end
    drive(8'hFE, 8'hFF, 4);
    drive(8'hFD, 8'hF9, 4);
    idle(2);
    checks++; if (stb_a - sa !== 2) begin errors++; $display("FAIL dp_stb_count actual=%0d required=%0d", stb_a - sa, 2); end
    checks++; if (inv_a !== 8'h01) begin errors++; $display("FAIL blank_invalid actual=%h required=%h", inv_a, 8'h01); end
    checks++; if (digits_a[7:0] !== 8'h10) begin errors++; $display("FAIL blank_nibble actual=%h required=%h", digits_a[7:0], 8'h10); end
    checks++; if (dp_a !== 8'h00) begin errors++; $display("FAIL blank_dp actual=%h required=%h", dp_a, 8'h00); end
  endtask

  task automatic test_reset_mid_frame;
    int sa;
    drive(8'hFE, 8'hC0, 4);
    idle(1);
    CLR = 1'b0;
    #1;
    checks++; if (digits_a !== 32'h0) begin errors++; $display("FAIL midreset_digits actual=%h required=%h", digits_a, 32'h0); end
    checks++; if (inv_a !== 8'h00) begin errors++; $display("FAIL midreset_invalid actual=%h required=%h", inv_a, 8'h00); end
    @(posedge CLK); #1 CLR = 1'b1;
    sa = stb_a;
    drive(8'hFD, 8'hF9, 4);
    idle(2);
    checks++; if (stb_a - sa !== 0) begin errors++; $display("FAIL midreset_partial actual=%0d required=%0d", stb_a - sa, 0); end
    drive(8'hFE, 8'hC0, 4);
    idle(2);
    checks++; if (stb_a - sa !== 1) begin errors++; $display("FAIL midreset_frame actual=%0d required=%0d", stb_a - sa, 1); end
    checks++; if (digits_a !== 32'h00000010) begin errors++; $display("FAIL midreset_digits_after actual=%h required=%h", digits_a, 32'h10); end
  endtask

  task automatic test_long_dwell;
    int sb;
    sb = stb_b;
    drive(8'hFE, 8'h99, 100);
    idle(2);
    checks++; if (stb_b - sb !== 1) begin errors++; $display("FAIL dwell_stb actual=%0d required=%0d", stb_b - sb, 1); end
    checks++; if (digits_b[3:0] !== 4'h4) begin errors++; $display("FAIL dwell_nibble actual=%h required=%h", digits_b[3:0], 4'h4); end
  endtask

  initial begin
    CLR = 1'b1; CE = 1'b0; E = 8'hFF; Q = 8'hFF;
    test_reset;
    test_capture;
    test_glitch;
    test_multi_enable;
    test_dp_invalid;
    test_reset_mid_frame;
    test_long_dwell;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/disp_7seg_rx.md
DISP_7SEG_RX -- requirements
Module: disp_7seg_rx

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 4: the number of consecutive identical CE samples needed to accept a digit (legal range 2..255).
REQ-002 The block SHALL have parameter FRAME_MASK, default 8'hFF: the digit positions that must be captured to complete a frame.
REQ-003 CLK  in  1  single clock; all state is updated on the rising edge.
REQ-004 CLR  in  1  reset, asynchronous, active-low.
REQ-005 CE  in  1  sample enable; a sample is taken only on cycles where CE=1.
REQ-006 E  in  8  digit enables, active-low; bit i selects position i.
REQ-007 Q  in  8  segments, active-low; Q[6:0]=g..a, Q[7]=DP.
REQ-008 DIGITS  out  32  decoded frame; nibble i (bits 4i+3:4i) is position i.
REQ-009 DP_OUT  out  8  captured decimal points, active-high.
REQ-010 INVALID  out  8  bit i=1 when position i held a pattern that is not a hex glyph (this includes blank).
REQ-011 FRAME_STB  out  1  one-CLK pulse issued when DIGITS, DP_OUT and INVALID update.
REQ-012 ERR  out  1  one-CLK pulse on a multi-digit-enable sample.

Function
REQ-013 On each CE sample the block SHALL compare {E,Q} with the previous sample.
- If equal: increment the stable counter, saturating at SETTLE_CYCLES.
- If different: clear the counter, store the new {E,Q} as the previous sample, and clear the accepted flag.
REQ-014 The block SHALL accept a digit when the counter reaches SETTLE_CYCLES-1 (SETTLE_CYCLES identical samples), E has exactly one zero bit, and the accepted flag is clear.
- Accepting sets the accepted flag, so each dwell is accepted at most once.
REQ-015 On accept, position i SHALL be written into the shadow registers: nibble, INVALID bit, DP bit. Seen bit i SHALL be set.
REQ-016 Decoding SHALL use the active-low hex table {0:7'h40, 1:7'h79, 2:7'h24, 3:7'h30, 4:7'h19, 5:7'h12, 6:7'h02, 7:7'h78, 8:7'h00, 9:7'h10, A:7'h08, b:7'h03, C:7'h46, d:7'h21, E:7'h06, F:7'h0E}.
- Any other pattern gives nibble 0 and INVALID=1.
REQ-017 E==8'hFF (no digit selected) SHALL never be accepted. It SHALL NOT raise ERR.
REQ-018 A sample with two or more zero bits in E SHALL pulse ERR on the CLK after the sample. The sample SHALL NOT be accepted, and the counter SHALL restart.
REQ-019 When (seen & FRAME_MASK)==FRAME_MASK after an accept, the following happens on the next CLK edge:
- DIGITS, DP_OUT and INVALID load from the shadow registers;
- FRAME_STB=1 for one cycle;
- seen clears.
REQ-020 Positions outside FRAME_MASK SHALL still be captured into the shadow registers and published with the next frame.
REQ-021 If a position is re-accepted before the frame completes, the newest value SHALL overwrite the shadow entry.
REQ-022 Outputs SHALL change only on a FRAME_STB cycle, apart from the ERR pulse.
REQ-023 Samples taken while CE=0 SHALL NOT exist: with CE=0 the counter, the previous sample and the seen bits hold.

Reset
REQ-024 CLR=0 SHALL immediately clear all of the following: DIGITS, DP_OUT, INVALID, FRAME_STB, ERR, shadow registers, seen bits, stable counter, accepted flag.
REQ-025 On reset the previous-sample register SHALL be set to {8'hFF,8'hFF}.
REQ-026 A reset asserted mid-frame SHALL discard the partial frame. The first frame after release requires all FRAME_MASK positions to be captured again.

Configuration
REQ-027 With macro DISP_7SEG_RX_DP_EN defined, Q[7] SHALL take part in the REQ-013 comparison and be captured into DP_OUT.
REQ-028 Without DISP_7SEG_RX_DP_EN, Q[7] SHALL be ignored in the comparison and DP_OUT SHALL be constant 8'h00.

Verification
REQ-029 Bench scenario, capture: SETTLE_CYCLES=4, FRAME_MASK=8'h03, CE every cycle; drive E=8'hFE,Q=8'hC0 for 4 samples, then E=8'hFD,Q=8'hF9 for 4 samples -> FRAME_STB pulses once, DIGITS[7:0]=8'h10, INVALID=8'h00.
REQ-030 Bench scenario, glitch: drive E=8'hFE,Q=8'hA4 for 3 samples, 1 sample of Q=8'hB0, then 4 samples of Q=8'hB0 -> nibble 0 = 4'h3, never 4'h2.
REQ-031 Bench scenario, multi-enable: E=8'hFC -> ERR pulses once, no accept, seen unchanged.
REQ-032 Bench scenario, DP and invalid glyph: with DISP_7SEG_RX_DP_EN defined, drive E=8'hFE,Q=8'h40 (DP on, glyph 0) -> DP_OUT[0]=1. Drive Q=8'hFF (blank) -> INVALID[0]=1 and nibble 0=4'h0.
REQ-033 Bench scenario, reset mid-frame: capture position 0 only with FRAME_MASK=8'h03, pulse CLR low, then capture position 1 only -> no FRAME_STB; capturing position 0 again produces the frame.
REQ-034 Bench scenario, long dwell: hold one digit for 100 samples with FRAME_MASK=8'h01 -> exactly one FRAME_STB.
